// File: rtl/iq_tx_buffer.sv
// Elastic IQ sample buffer feeding the FT600 write path: packs {Q, I} pairs into a
// first-word-fall-through FIFO with registered level/flags and a saturating drop counter.
module iq_tx_buffer #(
    parameter int IQ_PAIR_WIDTH = 24,
    parameter int DEPTH         = 2048,
    parameter int ENOUGH_LEVEL  = 1024,
    parameter int OVF_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        flush,
    input  logic [IQ_PAIR_WIDTH/2-1:0]  i_sample,
    input  logic [IQ_PAIR_WIDTH/2-1:0]  q_sample,
    input  logic                        in_valid,
    input  logic                        wr_req,
    output logic [IQ_PAIR_WIDTH-1:0]    wdata,
    output logic                        wr_empty,
    output logic                        wr_enough,
    output logic                        full,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow,
    output logic [OVF_CNT_WIDTH-1:0]    ovf_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [IQ_PAIR_WIDTH-1:0] ram [DEPTH];

    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic                     out_valid_q, out_valid_d;
    logic [IQ_PAIR_WIDTH-1:0] wdata_q, wdata_d;
    logic                     full_q, full_d;
    logic                     enough_q, enough_d;
    logic                     ovf_q, ovf_d;
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

    logic push, pop, push_acc, drop, ram_nonempty, load;

    always_comb begin
        push         = enable & in_valid & ~flush;
        pop          = wr_req & out_valid_q;
        push_acc     = push & (~full_q | pop);
        drop         = push & ~push_acc;
        // level includes the output register, so RAM holds level minus that slot
        ram_nonempty = (level_q != LW'(out_valid_q));
        load         = ~flush & (~out_valid_q | pop) & ram_nonempty;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        out_valid_d = out_valid_q;
        wdata_d     = wdata_q;
        ovf_d       = ovf_q;
        ovf_cnt_d   = ovf_cnt_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (load) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                wdata_d  = ram[rd_ptr_q];
            end
            out_valid_d = (out_valid_q & ~pop) | load;
            unique case ({push_acc, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_cnt_q != '1) begin
                ovf_cnt_d = ovf_cnt_q + OVF_CNT_WIDTH'(1);
            end
        end

        full_d   = (level_d == LW'(DEPTH));
        enough_d = (level_d >= LW'(ENOUGH_LEVEL));
    end

    // Sample storage carries no reset; its contents are only read behind valid pointers.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            ram[wr_ptr_q] <= {q_sample, i_sample};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_valid_q <= 1'b0;
            wdata_q     <= '0;
            full_q      <= 1'b0;
            enough_q    <= 1'b0;
            ovf_q       <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_valid_q <= out_valid_d;
            wdata_q     <= wdata_d;
            full_q      <= full_d;
            enough_q    <= enough_d;
            ovf_q       <= ovf_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign wdata     = wdata_q;
    assign wr_empty  = ~out_valid_q;
    assign wr_enough = enough_q;
    assign full      = full_q;
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign ovf_count = ovf_cnt_q;

endmodule
